// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  localparam logic [DEF_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on magnitudes, sign fix-up in a final cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = mdu_pkg::DEF_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: busy is high from the accepted start edge until the edge that
  // writes hi/lo; done pulses for exactly that one cycle, and start is only
  // sampled while busy is low (done=1 counts as idle, so back-to-back is legal).

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div0;

  logic                 op_signed;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       trial;
  logic                 ge;
  logic [WIDTH-1:0]     diff;
  logic [2*WIDTH-1:0]   next_acc;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     rem;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

  assign state_dbg = state;

  always_comb begin
    op_signed = ~op[0];
    a_abs     = abs_val(rs_data, op_signed);
    b_abs     = abs_val(rt_data, op_signed);

    // Multiply: low half holds the multiplier, consumed LSB first.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

    // Divide: partial remainder shifted left by one, compared with the divisor.
    trial     = acc[2*WIDTH-1:WIDTH-1];
    ge        = (trial >= {1'b0, opb});
    diff      = trial[WIDTH-1:0] - opb;

    if (is_div) begin
      next_acc = ge ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      next_acc = {mul_sum, acc[WIDTH-1:1]};
    end

    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_div <= op[1];
            acc    <= {{WIDTH{1'b0}}, a_abs};
            opb    <= b_abs;
            neg_q  <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r  <= op_signed & rs_data[WIDTH-1];
            div0   <= op[1] & (rt_data == '0);
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_CALC;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        ST_CALC: begin
          acc <= next_acc;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (!is_div) begin
            {hi, lo} <= prod;
          end else if (div0) begin
            // A zero divisor leaves |rs| in the remainder; the dividend-sign
            // rule then restores rs exactly.
            hi <= rem;
            lo <= DIV0_QUOT;
          end else begin
            hi <= rem;
            lo <= quot;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: reference products/quotients from
// 64-bit arithmetic, queued at launch and compared when done pulses.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  logic [2*W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, m;
    logic [2*W-1:0] r;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    exp_q.push_back(model(o, a, b));
    @(posedge clk); #1;
    start   = 1'b0;
    op      = 2'($urandom_range(0, 3));
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [W-1:0] d);
    mthi  = h;
    mtlo  = l;
    wdata = d;
    @(posedge clk); #1;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({hi, lo, busy, done} !== {64'h0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, want all zero", hi, lo, busy, done);
    end
    n_cmp++;
    if (state_dbg !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_fsm: state=%0d want 0", state_dbg);
    end
  endtask

  task automatic test_multu_max();
    logic [2*W-1:0] e;
    int busy_bad;
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_bad = (busy !== 1'b1) ? 1 : 0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
    end
    n_cmp++;
    if (busy_bad != 0) begin
      n_bad++;
      $display("FAIL multu_busy_window: %0d edges with busy!=1 or early done, want 0", busy_bad);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL multu_done_e33: done=%b busy=%b want done=1 busy=0", done, busy);
    end
    n_cmp++;
    if ({hi, lo} !== e) begin
      n_bad++;
      $display("FAIL multu_max_result: got %h_%h want %h_%h", hi, lo, e[63:32], e[31:0]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL multu_done_clear: done=%b want 0", done);
    end
  endtask

  task automatic test_vectors();
    logic [1:0]   ops[6] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10};
    logic [W-1:0] as[6]  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [W-1:0] bs[6]  = '{32'd7, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [2*W-1:0] want[6] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFD,
                                64'h0000_0001_0000_0003, 64'h0000_0005_FFFF_FFFF,
                                64'h0000_0000_8000_0000, 64'hFFFF_FFF9_FFFF_FFFF};
    logic [2*W-1:0] e;
    int lat;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      launch(ops[i], as[i], bs[i]);
      wait_done(lat, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || lat != 33) begin
        n_bad++;
        $display("FAIL vec%0d_latency: done_seen=%0d latency=%0d want 33", i, ok, lat);
      end
      n_cmp++;
      if ({hi, lo} !== want[i] || e !== want[i]) begin
        n_bad++;
        $display("FAIL vec%0d_result: got %h_%h want %h_%h", i, hi, lo, want[i][63:32], want[i][31:0]);
      end
    end
  endtask

  task automatic test_mt_write();
    mt_write(1'b0, 1'b1, 32'h0000_1234);
    n_cmp++;
    if (lo !== 32'h0000_1234) begin
      n_bad++;
      $display("FAIL mtlo_write: lo=%h want 00001234", lo);
    end
    mt_write(1'b1, 1'b1, 32'h0BAD_0BAD);
    n_cmp++;
    if ({hi, lo} !== {32'h0BAD_0BAD, 32'h0BAD_0BAD}) begin
      n_bad++;
      $display("FAIL mthi_mtlo_both: hi=%h lo=%h want 0bad0bad both", hi, lo);
    end
  endtask

  task automatic test_busy_ignore();
    logic [2*W-1:0] e;
    int lat;
    bit ok;
    launch(2'b11, 32'd7, 32'd2);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b00; rs_data = 32'd9; rt_data = 32'd9;
    mthi = 1'b1; wdata = 32'h0000_AAAA;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    n_cmp++;
    if ({hi, lo} !== {32'h0BAD_0BAD, 32'h0BAD_0BAD} || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_hold: hi=%h lo=%h busy=%b want 0bad0bad/0bad0bad busy=1", hi, lo, busy);
    end
    wait_done(lat, ok);
    lat += 6;
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || lat != 33 || {hi, lo} !== e) begin
      n_bad++;
      $display("FAIL busy_ignore_result: ok=%0d lat=%0d got %h_%h want %h_%h lat 33",
               ok, lat, hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_start_beats_mthi();
    logic [2*W-1:0] e;
    int lat;
    bit ok;
    mthi  = 1'b1;
    wdata = 32'h0000_AAAA;
    launch(2'b01, 32'd5, 32'd6);
    mthi  = 1'b0;
    n_cmp++;
    if (hi !== 32'h0000_0001 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL start_mthi_drop: hi=%h busy=%b want 00000001 busy=1", hi, busy);
    end
    wait_done(lat, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || {hi, lo} !== e) begin
      n_bad++;
      $display("FAIL start_mthi_result: got %h_%h want %h_%h", hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] e;
    int lat;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      launch(o, a, b);
      wait_done(lat, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || lat != 33 || {hi, lo} !== e) begin
        n_bad++;
        $display("FAIL b2b%0d op=%0d a=%h b=%h: ok=%0d lat=%0d got %h_%h want %h_%h",
                 i, o, a, b, ok, lat, hi, lo, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2*W-1:0] e;
    int lat;
    bit ok;
    launch(2'b01, 32'hFFFF_FFFF, 32'd2);
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    exp_q.delete();
    n_cmp++;
    if ({hi, lo, busy, done} !== {64'h0, 2'b00} || state_dbg !== 2'b00) begin
      n_bad++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b state=%0d want zeros/idle",
               hi, lo, busy, done, state_dbg);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    launch(2'b01, 32'd3, 32'd4);
    wait_done(lat, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || lat != 33 || {hi, lo} !== e || e !== 64'd12) begin
      n_bad++;
      $display("FAIL post_reset_multu: ok=%0d lat=%0d got %h_%h want 0_c lat 33", ok, lat, hi, lo);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_multu_max();
    test_vectors();
    test_mt_write();
    test_busy_ignore();
    test_start_beats_mthi();
    test_back_to_back();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
